// File: rtl/mole_round_ctrl_pkg.sv
// Shared definitions for the whack-a-mole round controller: FSM encoding,
// difficulty level codes, default timing constants and LFSR taps.
package mole_round_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_SHOW  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Level 2'b11 is decoded as hard (bit 1 set means hard).
    localparam logic [1:0] LVL_EZ   = 2'b00;
    localparam logic [1:0] LVL_MED  = 2'b01;
    localparam logic [1:0] LVL_HARD = 2'b10;

    // Show windows and gap length at a 100 MHz clock.
    localparam int DEF_WIN_EZ   = 50_000_000;
    localparam int DEF_WIN_MED  = 25_000_000;
    localparam int DEF_WIN_HARD = 12_500_000;
    localparam int DEF_GAP_CYC  = 10_000_000;

    // Galois right-shift mask for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR used to pick mole positions.
module mole_lfsr
    import mole_round_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q, lfsr_d;

    // Shift right; fold the taps back in when a one falls out of bit 0.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
    end

    // Advances every cycle; reset reloads the seed.
    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: spawns moles at pseudo-random holes, times
// the show window and the gap between spawns, and keeps score and misses.
module mole_round_ctrl
    import mole_round_ctrl_pkg::*;
#(
    parameter int          NUM_HOLES  = 8,
    parameter int          SCORE_W    = 6,
    parameter int          WIN_EZ     = DEF_WIN_EZ,
    parameter int          WIN_MED    = DEF_WIN_MED,
    parameter int          WIN_HARD   = DEF_WIN_HARD,
    parameter int          GAP_CYC    = DEF_GAP_CYC,
    parameter int          ROUNDS     = 20,
    parameter int          MISS_LIMIT = 10,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    localparam int         POS_W      = $clog2(NUM_HOLES)
) (
    input  logic                 CLK100MHZ,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           levl,
    input  logic                 hit_valid,
    input  logic [POS_W-1:0]     hit_pos,
    output logic [NUM_HOLES-1:0] mole_active,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   misses,
    output logic                 busy,
    output logic                 game_done
);

    localparam int MAX_WIN_A = (WIN_EZ > WIN_MED) ? WIN_EZ : WIN_MED;
    localparam int MAX_WIN   = (MAX_WIN_A > WIN_HARD) ? MAX_WIN_A : WIN_HARD;
    localparam int MAX_CNT   = (MAX_WIN > GAP_CYC) ? MAX_WIN : GAP_CYC;
    localparam int CNT_W     = $clog2(MAX_CNT + 1);
    localparam int RND_W     = $clog2(ROUNDS + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_e                 state_q, state_d;
    logic [NUM_HOLES-1:0]   mole_q, mole_d;
    logic [NUM_HOLES-1:0]   spawn_mask, hit_mask, live;
    logic [SCORE_W-1:0]     score_q, score_d, miss_q, miss_d;
    logic [RND_W-1:0]       round_q, round_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, win_load;
    logic [1:0]             lvl_q, lvl_d;
    logic                   busy_q, done_q;
    logic [15:0]            lfsr_w;
    logic [31:0]            pos_a, pos_b, live_cnt, miss_sum;

    mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i  (CLK100MHZ),
        .rst_i  (reset),
        .lfsr_o (lfsr_w)
    );

    // Primary hole from the LFSR; hard levels add the diametrically opposite hole.
    assign pos_a = {16'd0, lfsr_w} % 32'(NUM_HOLES);
    assign pos_b = (pos_a + 32'(NUM_HOLES / 2)) % 32'(NUM_HOLES);

    // Decode spawn pattern and the one-hot strike; out-of-range hit_pos decodes to nothing.
    always_comb begin
        spawn_mask = '0;
        hit_mask   = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            if (pos_a == 32'(i) || (lvl_q[1] && pos_b == 32'(i))) spawn_mask[i] = 1'b1;
            if (hit_valid && hit_pos == POS_W'(i))                 hit_mask[i]   = 1'b1;
        end
    end

    assign live = mole_q & ~hit_mask;

    // Moles still up after this cycle's strike, and the saturating-add operand for misses.
    always_comb begin
        live_cnt = '0;
        for (int i = 0; i < NUM_HOLES; i++) live_cnt = live_cnt + 32'(live[i]);
        miss_sum = 32'(miss_q) + live_cnt;
    end

    // Show window for the level latched at start.
    always_comb begin
        case (lvl_q)
            LVL_EZ:  win_load = CNT_W'(WIN_EZ - 1);
            LVL_MED: win_load = CNT_W'(WIN_MED - 1);
            default: win_load = CNT_W'(WIN_HARD - 1);
        endcase
    end

    // Next-state, counters and scoring.
    always_comb begin
        state_d = state_q;
        mole_d  = mole_q;
        score_d = score_q;
        miss_d  = miss_q;
        round_d = round_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SPAWN;
                    score_d = '0;
                    miss_d  = '0;
                    round_d = '0;
                    lvl_d   = levl;
                end
            end
            ST_SPAWN: begin
                mole_d  = spawn_mask;
                cnt_d   = win_load;
                round_d = round_q + RND_W'(1);
                state_d = ST_SHOW;
            end
            ST_SHOW: begin
                cnt_d  = cnt_q - CNT_W'(1);
                mole_d = live;
                if (|(mole_q & hit_mask))
                    score_d = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);
                if (live == '0 || cnt_q == '0) begin
                    // Only an expiring window charges misses; a cleared board charges none.
                    if (cnt_q == '0)
                        miss_d = (miss_sum > 32'(SCORE_MAX)) ? SCORE_MAX : miss_sum[SCORE_W-1:0];
                    mole_d  = '0;
                    cnt_d   = CNT_W'(GAP_CYC - 1);
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    if (round_q == RND_W'(ROUNDS) || 32'(miss_q) >= 32'(MISS_LIMIT))
                        state_d = ST_DONE;
                    else
                        state_d = ST_SPAWN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; busy/done are registered from the next state.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mole_q  <= '0;
            score_q <= '0;
            miss_q  <= '0;
            round_q <= '0;
            cnt_q   <= '0;
            lvl_q   <= LVL_EZ;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mole_q  <= mole_d;
            score_q <= score_d;
            miss_q  <= miss_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            busy_q  <= (state_d == ST_SPAWN) || (state_d == ST_SHOW) || (state_d == ST_GAP);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign mole_active = mole_q;
    assign score       = score_q;
    assign misses      = miss_q;
    assign busy        = busy_q;
    assign game_done   = done_q;

endmodule
